bin_to_bcd_seq: RTL

- Sequential binary-to-BCD converter using shift-and-add-3 ("double dabble"). One bit is processed per clock.
- Converts the parking-lot occupancy count into packed BCD digits. Each digit drives one `bcd_to_seven_seg` instance on the board displays.
- Uses a start/busy/done handshake. The result is held stable between conversions so the displays never flicker mid-conversion.

---
 rtl/bcd_pkg.sv | 19 +
 rtl/bcd_digit_adj.sv | 19 +
 rtl/bin_to_bcd_seq.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared types and constants for the sequential binary-to-BCD converter.
//   bcd_state_e     : converter FSM states (IDLE -> SHIFT -> DONE -> IDLE)
//   BCD_BLANK       : digit code the seven-segment decoder renders as blank
//   BCD_ADJ_THRESH  : digits at or above this value get +3 before a shift
// ---------------------------------------------------------------------------
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_e;

  localparam logic [3:0] BCD_BLANK      = 4'hF;
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;

endpackage

// File: rtl/bcd_digit_adj.sv
// ---------------------------------------------------------------------------
// bcd_digit_adj
// Combinational double-dabble digit correction: adds 3 to a BCD digit that
// is 5 or more, so that the following left shift carries correctly into the
// next decimal digit. The largest possible output is 4'hC (input 9).
// Ports:
//   din  : working BCD digit before correction
//   dout : corrected digit
// ---------------------------------------------------------------------------
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= BCD_ADJ_THRESH) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seq
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per
// clock. Converts the parking-lot occupancy count into packed BCD digits
// for the board's seven-segment displays. The published result is held
// between conversions so the displays never show intermediate values.
//
// Optional feature (macro BCD_LEADING_ZERO_BLANK_EN):
//   defined   - leading zero digits above digit 0 are published as 4'hF
//               (blank); reset value is all blank except digit 0 = 0.
//   undefined - digits published verbatim, reset value all zeros.
//
// Parameters:
//   BIN_W  : width of the binary input
//   DIGITS : number of BCD digits produced (digit 0 least significant)
// Ports:
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   start    : conversion request, sampled only in IDLE
//   bin      : binary value, captured on the accepting edge
//   busy     : high while the FSM is not IDLE
//   done     : one-cycle pulse, bcd/overflow valid from this cycle
//   bcd      : packed result, digit i at bits [4i+3:4i]
//   overflow : bin did not fit in DIGITS decimal digits
//
// Handshake: a request is accepted on a rising edge where start=1 and
// busy=0. Requests while busy (including the DONE cycle) are dropped, not
// queued. The result is published on the edge entering DONE; done is high
// for exactly that one cycle. bcd/overflow change only then or on reset.
//
// Debug: state_q holds the current FSM state (bcd_state_e) for checkers.
// ---------------------------------------------------------------------------
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W - 1);

`ifdef BCD_LEADING_ZERO_BLANK_EN
  // All digits blank except digit 0, which shows 0.
  localparam logic [BCD_W-1:0] BCD_RST = {BCD_W{1'b1}} << 4;
`else
  localparam logic [BCD_W-1:0] BCD_RST = '0;
`endif

  bcd_state_e        state_q;
  bcd_state_e        state_d;

  logic [BIN_W-1:0]  sh_q;        // remaining binary bits, MSB first
  logic [BCD_W-1:0]  work_q;      // working BCD digits
  logic              ovf_q;       // sticky: a bit fell off the top digit
  logic [CNT_W-1:0]  cnt_q;       // bits still to shift, minus one

  logic [BCD_W-1:0]  work_adj;    // working digits after +3 correction
  logic [BCD_W-1:0]  work_shift;  // working digits after this cycle's shift
  logic              ovf_next;
  logic              last_bit;

  logic [BCD_W-1:0]  bcd_fmt;     // final digits as they will be published
  logic [BCD_W-1:0]  bcd_q;
  logic              overflow_q;

  // ---------------------------------------------------------------------
  // Digit correction, one instance per digit
  // ---------------------------------------------------------------------
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (work_q[4*g +: 4]),
      .dout (work_adj[4*g +: 4])
    );
  end

  // The {BCD, shift} register moves left by one; the incoming bit is the
  // MSB of the binary shift register. The bit leaving the top digit is the
  // part of the value that does not fit, so it feeds the overflow flag.
  assign work_shift = {work_adj[BCD_W-2:0], sh_q[BIN_W-1]};
  assign ovf_next   = ovf_q | work_adj[BCD_W-1];
  assign last_bit   = (cnt_q == '0);

  // ---------------------------------------------------------------------
  // Output formatting of the final working digits
  // ---------------------------------------------------------------------
`ifdef BCD_LEADING_ZERO_BLANK_EN
  logic lead;
  always_comb begin
    bcd_fmt = work_shift;
    lead    = 1'b1;
    // Walk from the top digit down; stop blanking at the first non-zero.
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead && (work_shift[4*i +: 4] == 4'h0)) begin
        bcd_fmt[4*i +: 4] = BCD_BLANK;
      end else begin
        lead = 1'b0;
      end
    end
  end
`else
  assign bcd_fmt = work_shift;
`endif

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q       <= '0;
      work_q     <= '0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      bcd_q      <= BCD_RST;
      overflow_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            sh_q   <= bin;
            work_q <= '0;
            ovf_q  <= 1'b0;
            cnt_q  <= CNT_LOAD;
          end
        end
        SHIFT: begin
          sh_q   <= sh_q << 1;
          work_q <= work_shift;
          ovf_q  <= ovf_next;
          cnt_q  <= cnt_q - 1'b1;
          // Publish on the edge that enters DONE, using this cycle's
          // final shift so the result and done appear together.
          if (last_bit) begin
            bcd_q      <= bcd_fmt;
            overflow_q <= ovf_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign bcd      = bcd_q;
  assign overflow = overflow_q;

endmodule
